// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one single-port SRAM macro between the SPI programming/readback path
//   and the core datapath. Core has priority; a saturating wait counter forces a
//   pending SPI request through after MAX_SPI_WAIT consecutive denials.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   global_power_down          blocks all grants, chip_select forced low
//   spi_*  (req/write/address/data_in/mask)   SPI request fields
//   spi_gnt, spi_rvalid, spi_rdata            SPI grant and registered read return
//   core_* (req/write/address/data_in/mask)   core request fields
//   core_gnt, core_rvalid, core_rdata         core grant and passthrough read return
//   memory_data_out            macro read data, one cycle after a read issue
//   chip_select, write_enable, address, data_in, mask   macro pins
module memory_port_arbiter #(
  parameter int unsigned WORD_BIT_WIDTH    = 64,
  parameter int unsigned ADDRESS_BIT_WIDTH = 9,
  parameter int unsigned MAX_SPI_WAIT      = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         global_power_down,

  input  logic                         spi_req,
  input  logic                         spi_write,
  input  logic [ADDRESS_BIT_WIDTH-1:0] spi_address,
  input  logic [WORD_BIT_WIDTH-1:0]    spi_data_in,
  input  logic [WORD_BIT_WIDTH-1:0]    spi_mask,
  output logic                         spi_gnt,
  output logic                         spi_rvalid,
  output logic [WORD_BIT_WIDTH-1:0]    spi_rdata,

  input  logic                         core_req,
  input  logic                         core_write,
  input  logic [ADDRESS_BIT_WIDTH-1:0] core_address,
  input  logic [WORD_BIT_WIDTH-1:0]    core_data_in,
  input  logic [WORD_BIT_WIDTH-1:0]    core_mask,
  output logic                         core_gnt,
  output logic                         core_rvalid,
  output logic [WORD_BIT_WIDTH-1:0]    core_rdata,

  input  logic [WORD_BIT_WIDTH-1:0]    memory_data_out,
  output logic                         chip_select,
  output logic                         write_enable,
  output logic [ADDRESS_BIT_WIDTH-1:0] address,
  output logic [WORD_BIT_WIDTH-1:0]    data_in,
  output logic [WORD_BIT_WIDTH-1:0]    mask
);

  localparam int unsigned WaitWidth = (MAX_SPI_WAIT < 1) ? 1 : $clog2(MAX_SPI_WAIT + 1);
  localparam logic [WaitWidth-1:0] WaitMax = WaitWidth'(MAX_SPI_WAIT);

  // Owner of the read issued in the previous cycle.
  typedef enum logic [1:0] {TagIdle, TagSpi, TagCore} tag_e;

  logic [WaitWidth-1:0]      wait_q, wait_d;
  tag_e                      tag_q, tag_d;
  logic                      spi_rvalid_q, spi_rvalid_d;
  logic [WORD_BIT_WIDTH-1:0] spi_rdata_q, spi_rdata_d;
  logic                      spi_forced;

  // Arbitration
  always_comb begin
    spi_gnt    = 1'b0;
    core_gnt   = 1'b0;
    spi_forced = spi_req && (wait_q == WaitMax);
    if (!global_power_down) begin
      if (spi_forced) begin
        spi_gnt = 1'b1;
      end else if (core_req) begin
        core_gnt = 1'b1;
      end else if (spi_req) begin
        spi_gnt = 1'b1;
      end
    end
  end

  // Macro pins; write data and mask are zeroed on reads so the macro never
  // sees stale write fields.
  always_comb begin
    chip_select  = spi_gnt | core_gnt;
    write_enable = 1'b0;
    address      = '0;
    data_in      = '0;
    mask         = '0;
    if (core_gnt) begin
      write_enable = core_write;
      address      = core_address;
      if (core_write) begin
        data_in = core_data_in;
        mask    = core_mask;
      end
    end else if (spi_gnt) begin
      write_enable = spi_write;
      address      = spi_address;
      if (spi_write) begin
        data_in = spi_data_in;
        mask    = spi_mask;
      end
    end
  end

  // Wait counter keeps counting through power-down so a starved SPI request
  // wins as soon as power-down drops.
  always_comb begin
    if (!spi_req || spi_gnt) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_comb begin
    if (spi_gnt && !spi_write) begin
      tag_d = TagSpi;
    end else if (core_gnt && !core_write) begin
      tag_d = TagCore;
    end else begin
      tag_d = TagIdle;
    end
  end

  // SPI read data is captured into a holding register for the slow shifter.
  always_comb begin
    spi_rvalid_d = (tag_q == TagSpi);
    spi_rdata_d  = spi_rdata_q;
    if (tag_q == TagSpi) begin
      spi_rdata_d = memory_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q       <= '0;
      tag_q        <= TagIdle;
      spi_rvalid_q <= 1'b0;
      spi_rdata_q  <= '0;
    end else begin
      wait_q       <= wait_d;
      tag_q        <= tag_d;
      spi_rvalid_q <= spi_rvalid_d;
      spi_rdata_q  <= spi_rdata_d;
    end
  end

  assign spi_rvalid  = spi_rvalid_q;
  assign spi_rdata   = spi_rdata_q;
  assign core_rvalid = (tag_q == TagCore);
  assign core_rdata  = memory_data_out;

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;

  localparam int W = 64;
  localparam int A = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         global_power_down;
  logic         spi_req, spi_write;
  logic [A-1:0] spi_address;
  logic [W-1:0] spi_data_in, spi_mask;
  logic         spi_gnt, spi_rvalid;
  logic [W-1:0] spi_rdata;
  logic         core_req, core_write;
  logic [A-1:0] core_address;
  logic [W-1:0] core_data_in, core_mask;
  logic         core_gnt, core_rvalid;
  logic [W-1:0] core_rdata;
  logic [W-1:0] memory_data_out;
  logic         chip_select, write_enable;
  logic [A-1:0] address;
  logic [W-1:0] data_in, mask;

  memory_port_arbiter #(
    .WORD_BIT_WIDTH   (W),
    .ADDRESS_BIT_WIDTH(A),
    .MAX_SPI_WAIT     (15)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .global_power_down(global_power_down),
    .spi_req          (spi_req),
    .spi_write        (spi_write),
    .spi_address      (spi_address),
    .spi_data_in      (spi_data_in),
    .spi_mask         (spi_mask),
    .spi_gnt          (spi_gnt),
    .spi_rvalid       (spi_rvalid),
    .spi_rdata        (spi_rdata),
    .core_req         (core_req),
    .core_write       (core_write),
    .core_address     (core_address),
    .core_data_in     (core_data_in),
    .core_mask        (core_mask),
    .core_gnt         (core_gnt),
    .core_rvalid      (core_rvalid),
    .core_rdata       (core_rdata),
    .memory_data_out  (memory_data_out),
    .chip_select      (chip_select),
    .write_enable     (write_enable),
    .address          (address),
    .data_in          (data_in),
    .mask             (mask)
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten rows hold a fixed pattern, one-cycle read latency.
  logic [W-1:0] wr_mem [512];
  bit           wr_valid [512];
  logic [W-1:0] mem_rd;

  function automatic logic [W-1:0] pat(input logic [A-1:0] a);
    if (a == 9'h005) return 64'hDEADBEEF_01234567;
    return {16'hC0DE, 7'h0, a, 16'hBEEF, 7'h0, ~a};
  endfunction

  function automatic logic [W-1:0] rd(input logic [A-1:0] a);
    return wr_valid[a] ? wr_mem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    if (chip_select && !write_enable) mem_rd <= rd(address);
    if (chip_select && write_enable) begin
      wr_mem[address]   <= (rd(address) & ~mask) | (data_in & mask);
      wr_valid[address] <= 1'b1;
    end
  end
  assign memory_data_out = mem_rd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } rd_t;
  rd_t spi_q[$];
  rd_t core_q[$];

  typedef struct {
    logic         pd, sreq, swr;
    logic [A-1:0] saddr;
    logic [W-1:0] sdata, smask;
    logic         creq, cwr;
    logic [A-1:0] caddr;
    logic [W-1:0] cdata, cmask;
    logic         sg, cg, cs, we;
    logic [A-1:0] addr;
    logic [W-1:0] din, msk;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Scoreboard: read grants push the expected word, rvalid pulses pop it.
  task automatic monitor();
    rd_t e;
    if (spi_q.size() > 0 && spi_q[0].due < cyc) begin
      fail_now("spi_read_timeout");
      void'(spi_q.pop_front());
    end
    if (core_q.size() > 0 && core_q[0].due < cyc) begin
      fail_now("core_read_timeout");
      void'(core_q.pop_front());
    end
    if (spi_rvalid) begin
      if (spi_q.size() == 0) fail_now("spi_rvalid_unexpected");
      else begin
        e = spi_q.pop_front();
        chk("spi_latency", cyc, e.due);
        chk("spi_rdata", spi_rdata, e.data);
      end
    end
    if (core_rvalid) begin
      if (core_q.size() == 0) fail_now("core_rvalid_unexpected");
      else begin
        e = core_q.pop_front();
        chk("core_latency", cyc, e.due);
        chk("core_rdata", core_rdata, e.data);
      end
    end
    if (spi_gnt && !spi_write) spi_q.push_back('{cyc + 2, rd(spi_address)});
    if (core_gnt && !core_write) core_q.push_back('{cyc + 1, rd(core_address)});
  endtask

  task automatic half();
    @(negedge clk);
    monitor();
  endtask

  task automatic edge_step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic tick();
    half();
    edge_step();
  endtask

  task automatic idle_inputs();
    global_power_down = 1'b0;
    spi_req = 1'b0; spi_write = 1'b0; spi_address = '0; spi_data_in = '0; spi_mask = '0;
    core_req = 1'b0; core_write = 1'b0; core_address = '0; core_data_in = '0; core_mask = '0;
  endtask

  function automatic logic [255:0] pins();
    return {spi_gnt, core_gnt, chip_select, write_enable, address, data_in, mask};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{pd:0, sreq:0, swr:0, saddr:0, sdata:0, smask:0, creq:0, cwr:0, caddr:0,
                cdata:0, cmask:0, sg:0, cg:0, cs:0, we:0, addr:0, din:0, msk:0};
    vecs[1] = '{pd:0, sreq:0, swr:0, saddr:0, sdata:0, smask:0, creq:1, cwr:0, caddr:9'h005,
                cdata:64'h1111, cmask:'1, sg:0, cg:1, cs:1, we:0, addr:9'h005, din:0, msk:0};
    vecs[2] = '{pd:0, sreq:1, swr:1, saddr:9'h1FF, sdata:64'h0000FF00_00000000,
                smask:64'h0000FFFF_00000000, creq:0, cwr:0, caddr:0, cdata:0, cmask:0,
                sg:1, cg:0, cs:1, we:1, addr:9'h1FF, din:64'h0000FF00_00000000,
                msk:64'h0000FFFF_00000000};
    vecs[3] = '{pd:0, sreq:1, swr:0, saddr:9'h0AB, sdata:64'h77, smask:64'h77, creq:1, cwr:1,
                caddr:9'h033, cdata:64'h01234567_89ABCDEF, cmask:64'h00FF00FF_00FF00FF,
                sg:0, cg:1, cs:1, we:1, addr:9'h033, din:64'h01234567_89ABCDEF,
                msk:64'h00FF00FF_00FF00FF};
    vecs[4] = '{pd:1, sreq:1, swr:1, saddr:9'h001, sdata:64'h5, smask:64'h5, creq:1, cwr:0,
                caddr:9'h002, cdata:0, cmask:0, sg:0, cg:0, cs:0, we:0, addr:0, din:0, msk:0};
    vecs[5] = '{pd:0, sreq:1, swr:0, saddr:9'h0AB, sdata:64'hFFFF, smask:'1, creq:0, cwr:0,
                caddr:0, cdata:0, cmask:0, sg:1, cg:0, cs:1, we:0, addr:9'h0AB, din:0, msk:0};
    vecs[6] = '{pd:0, sreq:0, swr:0, saddr:0, sdata:0, smask:0, creq:1, cwr:0, caddr:9'h1FF,
                cdata:0, cmask:0, sg:0, cg:1, cs:1, we:0, addr:9'h1FF, din:0, msk:0};
    vecs[7] = '{pd:0, sreq:0, swr:0, saddr:0, sdata:0, smask:0, creq:1, cwr:0, caddr:9'h033,
                cdata:0, cmask:0, sg:0, cg:1, cs:1, we:0, addr:9'h033, din:0, msk:0};

    idle_inputs();
    rst_n = 1'b0;
    edge_step();
    half();
    chk("reset_outputs", {pins(), spi_rvalid, core_rvalid, spi_rdata}, '0);
    edge_step();
    rst_n = 1'b1;
    tick();
    half();
    chk("idle_after_reset", {pins(), spi_rvalid, core_rvalid, spi_rdata}, '0);
    edge_step();

    // Single-cycle combinational vectors, each separated by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      global_power_down = vecs[i].pd;
      spi_req = vecs[i].sreq; spi_write = vecs[i].swr; spi_address = vecs[i].saddr;
      spi_data_in = vecs[i].sdata; spi_mask = vecs[i].smask;
      core_req = vecs[i].creq; core_write = vecs[i].cwr; core_address = vecs[i].caddr;
      core_data_in = vecs[i].cdata; core_mask = vecs[i].cmask;
      half();
      chk($sformatf("vector%0d_pins", i), pins(),
          {vecs[i].sg, vecs[i].cg, vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].din,
           vecs[i].msk});
      edge_step();
      idle_inputs();
      tick();
    end
    repeat (3) tick();

    // Core hogs the port: SPI is forced through on the 16th cycle.
    core_req = 1'b1; core_write = 1'b0; core_address = 9'h020;
    spi_req = 1'b1; spi_write = 1'b1; spi_address = 9'h100;
    spi_data_in = 64'hA; spi_mask = 64'hF;
    for (int i = 0; i < 16; i++) begin
      half();
      chk($sformatf("starve%0d_spi_gnt", i), spi_gnt, (i == 15));
      chk($sformatf("starve%0d_core_gnt", i), core_gnt, (i != 15));
      edge_step();
    end
    spi_address = 9'h101;
    half();
    chk("after_force_gnts", {spi_gnt, core_gnt}, 2'b01);
    edge_step();
    idle_inputs();
    repeat (3) tick();

    // Back-to-back core then SPI reads.
    core_req = 1'b1; core_address = 9'h010;
    spi_req = 1'b1; spi_address = 9'h011;
    half();
    chk("alt_core_first", {spi_gnt, core_gnt}, 2'b01);
    edge_step();
    core_req = 1'b0;
    half();
    chk("alt_spi_second", {spi_gnt, core_gnt}, 2'b10);
    edge_step();
    idle_inputs();
    repeat (4) tick();
    half();
    chk("spi_rdata_hold", spi_rdata, pat(9'h011));
    edge_step();

    // Long power-down saturates the counter: SPI wins on release.
    global_power_down = 1'b1;
    core_req = 1'b1; core_address = 9'h040;
    spi_req = 1'b1; spi_address = 9'h041;
    for (int i = 0; i < 20; i++) begin
      half();
      chk($sformatf("pd%0d_blocked", i), {chip_select, spi_gnt, core_gnt}, 3'b000);
      edge_step();
    end
    global_power_down = 1'b0;
    half();
    chk("pd_release_forced_spi", {spi_gnt, core_gnt}, 2'b10);
    edge_step();
    spi_req = 1'b0;
    half();
    chk("pd_then_core", {spi_gnt, core_gnt}, 2'b01);
    edge_step();
    idle_inputs();
    repeat (3) tick();

    // Short power-down: counter not saturated, core wins on release.
    global_power_down = 1'b1;
    core_req = 1'b1; core_address = 9'h042;
    spi_req = 1'b1; spi_address = 9'h043;
    repeat (3) tick();
    global_power_down = 1'b0;
    half();
    chk("short_pd_core", {spi_gnt, core_gnt}, 2'b01);
    edge_step();
    core_req = 1'b0;
    half();
    chk("short_pd_spi_next", {spi_gnt, core_gnt}, 2'b10);
    edge_step();
    idle_inputs();
    repeat (4) tick();

    // Reset while an SPI read is in flight.
    spi_req = 1'b1; spi_write = 1'b0; spi_address = 9'h055;
    half();
    chk("rst_mid_read_gnt", spi_gnt, 1'b1);
    edge_step();
    idle_inputs();
    rst_n = 1'b0;
    spi_q.delete();
    core_q.delete();
    for (int i = 0; i < 3; i++) begin
      half();
      chk($sformatf("in_reset%0d_rvalid", i), spi_rvalid, 1'b0);
      edge_step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half();
      chk($sformatf("post_reset%0d_spi", i), {spi_rvalid, spi_rdata}, '0);
      edge_step();
    end

    chk("scoreboard_drained", spi_q.size() + core_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
